// File: rtl/usb_line_state_driver.sv
// USB raw line-state driver: arbitrates for the host TX port and drives J/K/SE0,
// either while a level enable is held or for a fixed number of timed writes.
module usb_line_state_driver #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LS_W         = 2,
    parameter int unsigned CNT_W        = 16,
    parameter logic [7:0]  CNTL_LINE    = 8'h00,
    parameter logic [7:0]  CNTL_RELEASE = 8'h05
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lvl_en,
    input  logic              timed_start,
    input  logic [CNT_W-1:0]  timed_cycles,
    input  logic              abort,
    input  logic [LS_W-1:0]   line_state,
    input  logic              tx_gnt,
    input  logic              tx_rdy,
    output logic              tx_req,
    output logic              tx_wen,
    output logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] tx_cntl,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] LINE_CODE = DATA_W'(CNTL_LINE);
    localparam logic [DATA_W-1:0] REL_CODE  = DATA_W'(CNTL_RELEASE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        DRV_RDY,
        DRV_CHK,
        REL_RDY,
        REL_END
    } state_t;

    typedef enum logic {
        MODE_LEVEL,
        MODE_TIMED
    } mode_t;

    state_t            state_q;
    mode_t             mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              tx_req_q;
    logic              tx_wen_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] tx_cntl_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_LEVEL;
            cnt_q     <= '0;
            tx_req_q  <= 1'b0;
            tx_wen_q  <= 1'b0;
            tx_data_q <= '0;
            tx_cntl_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // timed_start takes priority over a concurrent lvl_en
                    if (timed_start) begin
                        if (timed_cycles != '0) begin
                            cnt_q    <= timed_cycles;
                            mode_q   <= MODE_TIMED;
                            tx_req_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= WAIT_GNT;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else if (lvl_en) begin
                        mode_q   <= MODE_LEVEL;
                        tx_req_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (tx_gnt) begin
                        state_q <= DRV_RDY;
                    end
                end
                DRV_RDY: begin
                    if (tx_rdy) begin
                        tx_wen_q  <= 1'b1;
                        tx_data_q <= DATA_W'(line_state);
                        tx_cntl_q <= LINE_CODE;
                        if (mode_q == MODE_TIMED && cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                        state_q <= DRV_CHK;
                    end
                end
                DRV_CHK: begin
                    tx_wen_q <= 1'b0;
                    if (mode_q == MODE_LEVEL) begin
                        state_q <= lvl_en ? DRV_RDY : REL_RDY;
                    end else begin
                        state_q <= (cnt_q != '0 && !abort) ? DRV_RDY : REL_RDY;
                    end
                end
                REL_RDY: begin
                    if (tx_rdy) begin
                        tx_wen_q  <= 1'b1;
                        tx_data_q <= '0;
                        tx_cntl_q <= REL_CODE;
                        state_q   <= REL_END;
                    end
                end
                REL_END: begin
                    tx_wen_q <= 1'b0;
                    tx_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_req  = tx_req_q;
    assign tx_wen  = tx_wen_q;
    assign tx_data = tx_data_q;
    assign tx_cntl = tx_cntl_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_usb_line_state_driver.sv
// Bench for usb_line_state_driver: table of timed sessions plus hand-written
// sequences; every TX write is checked against a queue of expected writes.
module tb_usb_line_state_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        lvl_en;
    logic        timed_start;
    logic [15:0] timed_cycles;
    logic        abort;
    logic [1:0]  line_state;
    logic        tx_gnt;
    logic        tx_rdy;
    logic        tx_req;
    logic        tx_wen;
    logic [7:0]  tx_data;
    logic [7:0]  tx_cntl;
    logic        busy;
    logic        done;

    usb_line_state_driver dut (
        .clk          (clk),
        .rst          (rst),
        .lvl_en       (lvl_en),
        .timed_start  (timed_start),
        .timed_cycles (timed_cycles),
        .abort        (abort),
        .line_state   (line_state),
        .tx_gnt       (tx_gnt),
        .tx_rdy       (tx_rdy),
        .tx_req       (tx_req),
        .tx_wen       (tx_wen),
        .tx_data      (tx_data),
        .tx_cntl      (tx_cntl),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [1:0] ls;
        int         gdelay;
        int         stall;
        logic       ab;
        int         exp_lines;
    } vec_t;

    int total = 0;
    int bad = 0;
    int nwrites = 0;
    int ndone = 0;
    logic prev_wen = 1'b0;
    logic rdy_prev = 1'b0;
    logic [15:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard side: every write pops one expected {data, cntl}
    always @(negedge clk) begin
        if (rst) begin
            prev_wen = 1'b0;
            rdy_prev = 1'b0;
        end else begin
            if (tx_wen) begin
                logic [15:0] e;
                nwrites++;
                chk("wen_spacing", prev_wen, 0);
                chk("rdy_before_wen", rdy_prev, 1);
                chk("gnt_on_wen", tx_gnt, 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexp_write actual=%h/%h required=none",
                             tx_data, tx_cntl);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {tx_data, tx_cntl}, e);
                end
            end
            if (done) ndone++;
            prev_wen = tx_wen;
            rdy_prev = tx_rdy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            chk("busy_hold", busy, 1);
            step();
            k++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic end_sess(input int w0, input int d0, input int nw);
        step();
        chk("done_pulse", done, 0);
        chk("req_off", tx_req, 0);
        chk("busy_off", busy, 0);
        chk("n_writes", nwrites - w0, nw);
        chk("n_done", ndone - d0, 1);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic run_timed(input vec_t v);
        int w0 = nwrites;
        int d0 = ndone;
        for (int i = 0; i < v.exp_lines; i++)
            exp_q.push_back({6'b0, v.ls, 8'h00});
        exp_q.push_back(16'h0005);
        tx_gnt = (v.gdelay == 0);
        tx_rdy = 1'b1;
        abort = v.ab;
        line_state = v.ls;
        timed_cycles = 16'(v.n);
        timed_start = 1'b1;
        step();
        timed_start = 1'b0;
        chk("req_up", tx_req, 1);
        chk("busy_up", busy, 1);
        for (int i = 0; i < v.gdelay; i++) begin
            chk("no_wen_pre_gnt", tx_wen, 0);
            step();
        end
        tx_gnt = 1'b1;
        if (v.stall > 0) begin
            repeat (3) step();
            tx_rdy = 1'b0;
            repeat (v.stall) step();
            tx_rdy = 1'b1;
        end
        wait_done(200);
        abort = 1'b0;
        end_sess(w0, d0, v.exp_lines + 1);
        tx_gnt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tab[6];
        int w0;
        int d0;
        tab[0] = '{n: 3, ls: 2'b00, gdelay: 0, stall: 0, ab: 1'b0, exp_lines: 3};
        tab[1] = '{n: 1, ls: 2'b01, gdelay: 5, stall: 0, ab: 1'b0, exp_lines: 1};
        tab[2] = '{n: 3, ls: 2'b10, gdelay: 5, stall: 4, ab: 1'b0, exp_lines: 3};
        tab[3] = '{n: 5, ls: 2'b11, gdelay: 2, stall: 0, ab: 1'b0, exp_lines: 5};
        tab[4] = '{n: 1, ls: 2'b01, gdelay: 0, stall: 0, ab: 1'b1, exp_lines: 1};
        tab[5] = '{n: 4, ls: 2'b10, gdelay: 0, stall: 0, ab: 1'b1, exp_lines: 1};

        rst = 1'b1;
        lvl_en = 1'b1;
        timed_start = 1'b0;
        timed_cycles = '0;
        abort = 1'b0;
        line_state = 2'b01;
        tx_gnt = 1'b1;
        tx_rdy = 1'b1;

        // reset with lvl_en held, then a level session runs straight out of it
        repeat (2) begin
            step();
            chk("rst_outs", {tx_req, tx_wen, busy, done, tx_data, tx_cntl}, 0);
        end
        rst = 1'b0;
        w0 = nwrites;
        d0 = ndone;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0005);
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) chk("lvl_req_after_rst", tx_req, 1);
            if (k == 5) line_state = 2'b10;
            if (k == 9) lvl_en = 1'b0;
        end
        wait_done(50);
        end_sess(w0, d0, 6);

        for (int i = 0; i < 6; i++) run_timed(tab[i]);

        // zero-length timed request
        d0 = ndone;
        timed_cycles = '0;
        timed_start = 1'b1;
        step();
        timed_start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_req", tx_req, 0);
        chk("zero_busy", busy, 0);
        step();
        chk("zero_done_once", done, 0);
        chk("zero_req_after", tx_req, 0);
        chk("zero_n_done", ndone - d0, 1);

        // abort right after the first write of a long session
        w0 = nwrites;
        d0 = ndone;
        exp_q.push_back(16'h0300);
        exp_q.push_back(16'h0005);
        tx_gnt = 1'b1;
        tx_rdy = 1'b1;
        line_state = 2'b11;
        timed_cycles = 16'd100;
        timed_start = 1'b1;
        step();
        timed_start = 1'b0;
        for (int k = 0; k < 20 && !tx_wen; k++) step();
        chk("abort_first_wen", tx_wen, 1);
        abort = 1'b1;
        wait_done(100);
        abort = 1'b0;
        end_sess(w0, d0, 2);

        // timed_start with lvl_en wins; a restart while busy is ignored
        w0 = nwrites;
        d0 = ndone;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0005);
        line_state = 2'b01;
        lvl_en = 1'b1;
        timed_cycles = 16'd2;
        timed_start = 1'b1;
        step();
        timed_start = 1'b0;
        repeat (2) step();
        timed_cycles = 16'd50;
        timed_start = 1'b1;
        step();
        timed_start = 1'b0;
        wait_done(100);
        lvl_en = 1'b0;
        end_sess(w0, d0, 3);

        // reset while stalled in the drive state: no release write follows
        w0 = nwrites;
        tx_gnt = 1'b1;
        tx_rdy = 1'b0;
        timed_cycles = 16'd5;
        timed_start = 1'b1;
        step();
        timed_start = 1'b0;
        repeat (2) step();
        chk("midrst_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("midrst_outs", {tx_req, tx_wen, busy, done, tx_data, tx_cntl}, 0);
        rst = 1'b0;
        tx_rdy = 1'b1;
        tx_gnt = 1'b0;
        repeat (4) step();
        chk("midrst_no_write", nwrites - w0, 0);
        chk("midrst_req", tx_req, 0);
        run_timed(tab[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
